alu_arbiter: RTL and testbench
==============================

Name: alu_arbiter

Overview:
Shares the single-cycle ALU between two requesters, port 0 and port 1. Port 0 is the pipeline execute stage and port 1 is the address/compare helper. The block arbitrates round-robin and computes the result with an internal ALU function. It returns the registered result through a one-entry response buffer with valid/ready backpressure. It sits between the issue logic and the ALU datapath, replacing direct ALU wiring.

Parameters:
WIDTH, 32, operand/result width in bits
CNT_W, 16, width of the accepted-operation counter

Ports:
clk  input  1  system clock, rising edge
reset_n  input  1  asynchronous active-low reset
req0_valid  input  1  port 0 request valid
req0_ready  output  1  port 0 request accepted this cycle (grant)
req0_a  input  WIDTH  port 0 operand 1
req0_b  input  WIDTH  port 0 operand 2
req0_op  input  3  port 0 aluop
req1_valid  input  1  port 1 request valid
req1_ready  output  1  port 1 request accepted this cycle (grant)
req1_a  input  WIDTH  port 1 operand 1
req1_b  input  WIDTH  port 1 operand 2
req1_op  input  3  port 1 aluop
rsp_valid  output  1  response buffer holds a result
rsp_ready  input  1  consumer takes the response this cycle
rsp_data  output  WIDTH  ALU result
rsp_id  output  1  requester that owns rsp_data
rsp_err  output  1  aluop was not a defined encoding
op_count  output  CNT_W  saturating count of accepted requests

Behaviour:
- Reset (async, reset_n=0) values:
  - rsp_valid=0, rsp_data=0, rsp_id=0, rsp_err=0, op_count=0.
  - last_grant=1, so port 0 wins the first contention.
  - Reset mid-transaction discards any buffered response. No request is accepted while reset_n=0.
- Buffer availability: can_accept = !rsp_valid || rsp_ready.
- Grant logic is combinational, from req*_valid, last_grant and can_accept:
  - Only one valid: grant that port.
  - Both valid: grant the port != last_grant.
  - can_accept=0: no grant; req0_ready = req1_ready = 0.
  - At most one ready is high in any cycle. ready never depends on the op value.
- Accept edge: on a rising edge with a grant:
  - rsp_data <= ALU(a, b, op) of the granted port.
  - rsp_id <= granted port; rsp_valid <= 1; last_grant <= granted port.
  - op_count increments, saturating at all-ones.
- Latency: result is visible exactly 1 cycle after the accept edge.
- Drain: rsp_ready=1 with rsp_valid=1 and no new grant → rsp_valid <= 0. rsp_data, rsp_id and rsp_err hold their old values.
- Throughput: a simultaneous drain and accept in one cycle is allowed, giving one result per cycle.
- Stall: rsp_valid=1 and rsp_ready=0 → rsp_data, rsp_id and rsp_err are held stable, and no grants are issued.
- ALU function (WIDTH-bit, unsigned, wrap-around):
  - 000 AND, 001 OR.
  - 010 ADD: carry discarded.
  - 110 SUB: borrow discarded, wraps modulo 2^WIDTH.
  - 111 SLT: result 1 if a<b unsigned, else 0.
  - Any other op (011, 100, 101): result 0 and rsp_err=1. The request is still accepted and counted.
- Requesters must hold valid and operands until ready. The block does not check this.
- last_grant updates only on an accepted request, never on an idle cycle.

Test Plan:
- Reset then single request, port 0: a=7, b=5, op=010 → req0_ready=1 that cycle; next cycle rsp_valid=1, rsp_data=12, rsp_id=0, rsp_err=0, op_count=1.
- Contention: both ports valid for 4 cycles with rsp_ready=1 → grants go 0,1,0,1; rsp_id sequence is 0,1,0,1; one result per cycle.
- Backpressure: rsp_ready=0 while rsp_valid=1 and both ports valid → both readys stay 0 and rsp_data holds; raise rsp_ready → next grant is issued the same cycle.
- Arithmetic edges:
  - port 1, a=0, b=1, op=110 → rsp_data=0xFFFFFFFF.
  - a=0xFFFFFFFF, b=1, op=010 → 0.
  - a=0x80000000, b=1, op=111 → 0 (unsigned).
  - a=3, b=9, op=111 → 1.
- Illegal op: op=100, a=5, b=5 → rsp_data=0, rsp_err=1, op_count increments. A following op=001 clears rsp_err.
- Async reset: assert reset_n=0 mid-cycle with rsp_valid=1 → rsp_valid drops immediately, without waiting for a clock edge. After release, port 0 wins the first contention.

Source files
------------

// File: rtl/alu_arbiter_if.sv
// Request/response bundle between the two ALU requesters, the response consumer and alu_arbiter.
// The master side drives requests and rsp_ready; the slave side (the arbiter) drives grants and results.
interface alu_arbiter_if #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
);
    logic             req0_valid;
    logic             req0_ready;
    logic [WIDTH-1:0] req0_a;
    logic [WIDTH-1:0] req0_b;
    logic [2:0]       req0_op;
    logic             req1_valid;
    logic             req1_ready;
    logic [WIDTH-1:0] req1_a;
    logic [WIDTH-1:0] req1_b;
    logic [2:0]       req1_op;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] rsp_data;
    logic             rsp_id;
    logic             rsp_err;
    logic [CNT_W-1:0] op_count;

    modport master (
        output req0_valid, req0_a, req0_b, req0_op,
        output req1_valid, req1_a, req1_b, req1_op,
        output rsp_ready,
        input  req0_ready, req1_ready,
        input  rsp_valid, rsp_data, rsp_id, rsp_err, op_count
    );

    modport slave (
        input  req0_valid, req0_a, req0_b, req0_op,
        input  req1_valid, req1_a, req1_b, req1_op,
        input  rsp_ready,
        output req0_ready, req1_ready,
        output rsp_valid, rsp_data, rsp_id, rsp_err, op_count
    );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one single-cycle ALU between two requesters,
// returning the registered result through a one-entry valid/ready response buffer.
module alu_arbiter #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
) (
    input logic          clk,
    input logic          reset_n,
    alu_arbiter_if.slave bus
);

    logic             last_grant;
    logic             can_accept;
    logic             grant0;
    logic             grant1;
    logic             grant_any;
    logic [WIDTH-1:0] sel_a;
    logic [WIDTH-1:0] sel_b;
    logic [2:0]       sel_op;
    logic [WIDTH-1:0] alu_res;
    logic             alu_err;

    // Both valid: the port that did not win last time gets the ALU; grants are held off while in reset.
    always_comb begin
        can_accept = !bus.rsp_valid || bus.rsp_ready;
        grant0     = reset_n && can_accept && bus.req0_valid && (!bus.req1_valid || last_grant);
        grant1     = reset_n && can_accept && bus.req1_valid && (!bus.req0_valid || !last_grant);
        grant_any  = grant0 || grant1;
        sel_a      = grant1 ? bus.req1_a  : bus.req0_a;
        sel_b      = grant1 ? bus.req1_b  : bus.req0_b;
        sel_op     = grant1 ? bus.req1_op : bus.req0_op;
    end

    assign bus.req0_ready = grant0;
    assign bus.req1_ready = grant1;

    // Unsigned wrap-around ALU; undefined encodings still complete, flagged by alu_err.
    always_comb begin
        alu_res = '0;
        alu_err = 1'b0;
        case (sel_op)
            3'b000:  alu_res = sel_a & sel_b;
            3'b001:  alu_res = sel_a | sel_b;
            3'b010:  alu_res = sel_a + sel_b;
            3'b110:  alu_res = sel_a - sel_b;
            3'b111:  alu_res = {{(WIDTH-1){1'b0}}, (sel_a < sel_b)};
            default: alu_err = 1'b1;
        endcase
    end

    // An accept overrides a same-cycle drain, so a full buffer still yields one result per cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bus.rsp_valid <= 1'b0;
            bus.rsp_data  <= '0;
            bus.rsp_id    <= 1'b0;
            bus.rsp_err   <= 1'b0;
            bus.op_count  <= '0;
            last_grant    <= 1'b1;
        end else if (grant_any) begin
            bus.rsp_valid <= 1'b1;
            bus.rsp_data  <= alu_res;
            bus.rsp_id    <= grant1;
            bus.rsp_err   <= alu_err;
            last_grant    <= grant1;
            if (bus.op_count != {CNT_W{1'b1}}) begin
                bus.op_count <= bus.op_count + CNT_W'(1);
            end
        end else if (bus.rsp_ready) begin
            bus.rsp_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: a cycle-level reference model checked every cycle,
// plus hand-computed expectations at the interesting points of the sequence.
module tb_alu_arbiter;

    localparam int WIDTH = 32;
    localparam int CNT_W = 4;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic clk;
    logic reset_n;
    int   vectors;
    int   miscompares;

    alu_arbiter_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

    alu_arbiter #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state: what the response buffer must hold, and who won last.
    logic             m_valid;
    logic [WIDTH-1:0] m_data;
    logic             m_id;
    logic             m_err;
    int               m_count;
    logic             m_last;

    function automatic logic [WIDTH:0] alu_ref(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                               input logic [2:0] op);
        logic [WIDTH-1:0] r;
        logic             e;
        r = '0;
        e = 1'b0;
        case (op)
            3'd0:    r = a & b;
            3'd1:    r = a | b;
            3'd2:    r = a + b;
            3'd6:    r = a - b;
            3'd7:    r = (a < b) ? 1 : 0;
            default: e = 1'b1;
        endcase
        return {e, r};
    endfunction

    // Returns {grant1, grant0} derived from the arbitration rules.
    function automatic logic [1:0] predict_grant(input logic last, input logic v0, input logic v1,
                                                 input logic full, input logic rr);
        if (full && !rr) return 2'b00;
        if (v0 && v1)    return last ? 2'b01 : 2'b10;
        if (v0)          return 2'b01;
        if (v1)          return 2'b10;
        return 2'b00;
    endfunction

    always @(posedge clk or negedge reset_n) begin
        logic [1:0]     g;
        logic [WIDTH:0] res;
        if (!reset_n) begin
            m_valid = 1'b0;
            m_data  = '0;
            m_id    = 1'b0;
            m_err   = 1'b0;
            m_count = 0;
            m_last  = 1'b1;
        end else begin
            g = predict_grant(m_last, bus.req0_valid, bus.req1_valid, m_valid, bus.rsp_ready);
            if (g != 2'b00) begin
                res     = g[1] ? alu_ref(bus.req1_a, bus.req1_b, bus.req1_op)
                               : alu_ref(bus.req0_a, bus.req0_b, bus.req0_op);
                m_data  = res[WIDTH-1:0];
                m_err   = res[WIDTH];
                m_id    = g[1];
                m_last  = g[1];
                m_valid = 1'b1;
                if (m_count < int'(CNT_MAX)) m_count = m_count + 1;
            end else if (bus.rsp_ready) begin
                m_valid = 1'b0;
            end
        end
    end

    task automatic checkOutput(input string name, input logic [WIDTH-1:0] actual,
                               input logic [WIDTH-1:0] expected);
        vectors = vectors + 1;
        if (actual !== expected) begin
            miscompares = miscompares + 1;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Every falling edge out of reset, the DUT must agree with the model.
    always @(negedge clk) begin
        logic [1:0] g;
        if (reset_n) begin
            g = predict_grant(m_last, bus.req0_valid, bus.req1_valid, m_valid, bus.rsp_ready);
            checkOutput("model_req0_ready", WIDTH'(bus.req0_ready), WIDTH'(g[0]));
            checkOutput("model_req1_ready", WIDTH'(bus.req1_ready), WIDTH'(g[1]));
            checkOutput("model_rsp_valid",  WIDTH'(bus.rsp_valid),  WIDTH'(m_valid));
            checkOutput("model_rsp_data",   bus.rsp_data,           m_data);
            checkOutput("model_rsp_id",     WIDTH'(bus.rsp_id),     WIDTH'(m_id));
            checkOutput("model_rsp_err",    WIDTH'(bus.rsp_err),    WIDTH'(m_err));
            checkOutput("model_op_count",   WIDTH'(bus.op_count),   WIDTH'(m_count));
        end
    end

    task automatic applyStimulus(input logic v0, input logic [WIDTH-1:0] a0, input logic [WIDTH-1:0] b0,
                                 input logic [2:0] op0, input logic v1, input logic [WIDTH-1:0] a1,
                                 input logic [WIDTH-1:0] b1, input logic [2:0] op1, input logic rr);
        bus.req0_valid = v0;
        bus.req0_a     = a0;
        bus.req0_b     = b0;
        bus.req0_op    = op0;
        bus.req1_valid = v1;
        bus.req1_a     = a1;
        bus.req1_b     = b1;
        bus.req1_op    = op1;
        bus.rsp_ready  = rr;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [WIDTH-1:0] arith_a  [3];
    logic [WIDTH-1:0] arith_b  [3];
    logic [2:0]       arith_op [3];
    logic [WIDTH-1:0] arith_exp[3];

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset_n     = 1'b0;
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1);
        repeat (2) tick();
        reset_n = 1'b1;
        #1;
        checkOutput("reset_rsp_valid", WIDTH'(bus.rsp_valid), 0);
        checkOutput("reset_rsp_data",  bus.rsp_data, 0);
        checkOutput("reset_op_count",  WIDTH'(bus.op_count), 0);

        // Single port 0 request: 7 + 5
        applyStimulus(1, 7, 5, 3'b010, 0, 0, 0, 0, 1);
        #1;
        checkOutput("single_req0_ready", WIDTH'(bus.req0_ready), 1);
        checkOutput("single_req1_ready", WIDTH'(bus.req1_ready), 0);
        tick();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1);
        checkOutput("single_rsp_valid", WIDTH'(bus.rsp_valid), 1);
        checkOutput("single_rsp_data",  bus.rsp_data, 12);
        checkOutput("single_rsp_id",    WIDTH'(bus.rsp_id), 0);
        checkOutput("single_rsp_err",   WIDTH'(bus.rsp_err), 0);
        checkOutput("single_op_count",  WIDTH'(bus.op_count), 1);

        // Port 1 subtract wraps: 0 - 1
        applyStimulus(0, 0, 0, 0, 1, 0, 1, 3'b110, 1);
        tick();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1);
        checkOutput("sub_wrap_data", bus.rsp_data, 32'hFFFF_FFFF);
        checkOutput("sub_wrap_id",   WIDTH'(bus.rsp_id), 1);

        // Contention, port 1 won last: expect 0,1,0,1 back to back
        applyStimulus(1, 10, 3, 3'b010, 1, 10, 3, 3'b110, 1);
        for (int i = 0; i < 4; i++) begin
            tick();
            checkOutput("contention_id",   WIDTH'(bus.rsp_id), WIDTH'(i % 2));
            checkOutput("contention_data", bus.rsp_data, (i % 2 == 1) ? 7 : 13);
        end
        checkOutput("contention_op_count", WIDTH'(bus.op_count), 6);

        // Backpressure: full buffer and no consumer blocks both ports
        bus.rsp_ready = 1'b0;
        #1;
        checkOutput("stall_req0_ready", WIDTH'(bus.req0_ready), 0);
        checkOutput("stall_req1_ready", WIDTH'(bus.req1_ready), 0);
        tick();
        tick();
        checkOutput("stall_rsp_data",  bus.rsp_data, 7);
        checkOutput("stall_rsp_id",    WIDTH'(bus.rsp_id), 1);
        checkOutput("stall_rsp_valid", WIDTH'(bus.rsp_valid), 1);
        bus.rsp_ready = 1'b1;
        #1;
        checkOutput("release_req0_ready", WIDTH'(bus.req0_ready), 1);
        checkOutput("release_req1_ready", WIDTH'(bus.req1_ready), 0);
        tick();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1);
        checkOutput("release_rsp_id",   WIDTH'(bus.rsp_id), 0);
        checkOutput("release_rsp_data", bus.rsp_data, 13);
        tick();
        checkOutput("drain_rsp_valid", WIDTH'(bus.rsp_valid), 0);
        checkOutput("drain_rsp_data",  bus.rsp_data, 13);

        // Arithmetic edge cases on port 0
        arith_a[0] = 32'hFFFF_FFFF; arith_b[0] = 1; arith_op[0] = 3'b010; arith_exp[0] = 0;
        arith_a[1] = 32'h8000_0000; arith_b[1] = 1; arith_op[1] = 3'b111; arith_exp[1] = 0;
        arith_a[2] = 3;             arith_b[2] = 9; arith_op[2] = 3'b111; arith_exp[2] = 1;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1, arith_a[i], arith_b[i], arith_op[i], 0, 0, 0, 0, 1);
            tick();
            checkOutput("arith_data", bus.rsp_data, arith_exp[i]);
        end

        // Undefined op still counts; a defined op clears the error flag
        applyStimulus(1, 5, 5, 3'b100, 0, 0, 0, 0, 1);
        tick();
        checkOutput("illegal_data",     bus.rsp_data, 0);
        checkOutput("illegal_err",      WIDTH'(bus.rsp_err), 1);
        checkOutput("illegal_op_count", WIDTH'(bus.op_count), 11);
        applyStimulus(1, 5, 2, 3'b001, 0, 0, 0, 0, 1);
        tick();
        checkOutput("or_data",     bus.rsp_data, 7);
        checkOutput("or_err",      WIDTH'(bus.rsp_err), 0);
        checkOutput("or_op_count", WIDTH'(bus.op_count), 12);

        // Six more accepts push the 4-bit counter past its ceiling
        applyStimulus(0, 0, 0, 0, 1, 1, 2, 3'b001, 1);
        repeat (6) tick();
        checkOutput("sat_op_count", WIDTH'(bus.op_count), WIDTH'(CNT_MAX));
        checkOutput("sat_rsp_data", bus.rsp_data, 3);

        // Async reset mid-cycle with a response held in the buffer
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        checkOutput("pre_reset_valid", WIDTH'(bus.rsp_valid), 1);
        #2;
        reset_n = 1'b0;
        #1;
        checkOutput("async_reset_valid", WIDTH'(bus.rsp_valid), 0);
        checkOutput("async_reset_count", WIDTH'(bus.op_count), 0);
        applyStimulus(1, 10, 3, 3'b010, 1, 10, 3, 3'b110, 1);
        #1;
        checkOutput("in_reset_req0_ready", WIDTH'(bus.req0_ready), 0);
        checkOutput("in_reset_req1_ready", WIDTH'(bus.req1_ready), 0);
        tick();
        checkOutput("in_reset_valid", WIDTH'(bus.rsp_valid), 0);
        reset_n = 1'b1;
        #1;
        checkOutput("post_reset_req0_ready", WIDTH'(bus.req0_ready), 1);
        checkOutput("post_reset_req1_ready", WIDTH'(bus.req1_ready), 0);
        tick();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1);
        checkOutput("post_reset_id",    WIDTH'(bus.rsp_id), 0);
        checkOutput("post_reset_data",  bus.rsp_data, 13);
        checkOutput("post_reset_count", WIDTH'(bus.op_count), 1);
        repeat (2) tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
